ahb_sram_slave: RTL and testbench

//  AHB-Lite memory slave directly downstream of the AHB master: accepts its address/control phase and

---
 rtl/ahb_sram_slave_pkg.sv | 52 +++++
 rtl/ahb_sram_slave_array.sv | 34 +++
 rtl/ahb_sram_slave.sv | 146 ++++++++++++++
 tb/tb_ahb_sram_slave.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite definitions: transfer types, size/response encodings,
// SRAM slave FSM states and byte-lane helpers.
package AHP_MASTER_PKG;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY    = 2'b01,
    NON_SEQ = 2'b10,
    SEQ     = 2'b11
  } HTRANS_ENUM;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } slave_state_e;

  // Little-endian lane enables; unsupported sizes enable nothing.
  function automatic logic [3:0] lane_enables(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic access_aligned(input logic [2:0] size, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = ~addr_lo[0];
      HSIZE_WORD: ok = (addr_lo == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahb_sram_slave_array.sv
// Word-organised SRAM built from four byte-lane arrays: per-lane write enables,
// registered read-first read so a same-edge write leaves the old word on rdata.
module ahb_sram_array #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  HCLK,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_reg;

    always_ff @(posedge HCLK) begin
      if (we && be[gi]) begin
        mem[waddr] <= wdata[8*gi +: 8];
      end
      if (re) begin
        rdata_reg <= mem[raddr];
      end
    end

    assign rdata[8*gi +: 8] = rdata_reg;
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: address-phase decode and legality, wait-state FSM,
// two-cycle ERROR response, and write-to-read forwarding for pipelined accesses.
module ahb_sram_slave
  import AHP_MASTER_PKG::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               HSEL,
  input  logic [31:0]        HADDR,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [2:0]         HBURST,
  input  HTRANS_ENUM         HTRANS,
  input  logic signed [31:0] HWDATA,
  input  logic               HREADY,
  output logic               HREADYOUT,
  output logic               HRESP,
  output logic signed [31:0] HRDATA
);

  localparam logic [2:0] WS_LAST = 3'(WAIT_STATES);

  slave_state_e state_reg, state_next;
  logic [2:0]            wait_cnt_reg, wait_cnt_next;
  logic                  wr_reg;
  logic [3:0]            be_reg;
  logic [ADDR_WIDTH-1:0] idx_reg;
  logic                  fwd_hit_reg;
  logic [3:0]            fwd_be_reg;
  logic [31:0]           fwd_data_reg;

  logic [31:0]           offset;
  logic [ADDR_WIDTH-1:0] idx;
  logic [3:0]            be;
  logic                  in_range;
  logic                  legal;
  logic                  ready_state;
  logic                  accept;
  logic                  commit;
  logic                  ram_re;
  logic [31:0]           ram_rdata;
  logic [31:0]           rd_word;
  logic                  unused_burst;

  assign unused_burst = ^HBURST;

  // Address decode relative to the window base; no wrap past the top.
  assign offset   = HADDR - BASE_ADDR;
  assign idx      = offset[ADDR_WIDTH+1:2];
  assign in_range = (HADDR >= BASE_ADDR) && ((offset >> (ADDR_WIDTH + 2)) == 32'd0);
  assign legal    = in_range && access_aligned(HSIZE, HADDR[1:0]);
  assign be       = lane_enables(HSIZE, HADDR[1:0]);

  assign ready_state = (state_reg != S_WAIT) && (state_reg != S_ERR1);
  assign accept      = ready_state && HSEL && HREADY && ((HTRANS == NON_SEQ) || (HTRANS == SEQ));
  assign commit      = (state_reg == S_DATA) && wr_reg;
  assign ram_re      = accept && legal && !HWRITE;

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    HREADYOUT     = ready_state;
    HRESP         = HRESP_OKAY;
    case (state_reg)
      S_WAIT: begin
        if (wait_cnt_reg == WS_LAST) begin
          state_next    = S_DATA;
          wait_cnt_next = 3'd0;
        end else begin
          wait_cnt_next = wait_cnt_reg + 3'd1;
        end
      end
      S_ERR1: begin
        HRESP      = HRESP_ERROR;
        state_next = S_ERR2;
      end
      S_IDLE, S_DATA, S_ERR2: begin
        if (state_reg == S_ERR2) begin
          HRESP = HRESP_ERROR;
        end
        state_next = S_IDLE;
        if (accept) begin
          if (!legal) begin
            state_next = S_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_next    = S_WAIT;
            wait_cnt_next = 3'd1;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= 3'd0;
      wr_reg       <= 1'b0;
      be_reg       <= 4'b0000;
      idx_reg      <= '0;
      fwd_hit_reg  <= 1'b0;
      fwd_be_reg   <= 4'b0000;
      fwd_data_reg <= 32'h0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (accept) begin
        wr_reg       <= HWRITE && legal;
        be_reg       <= be;
        idx_reg      <= idx;
        // A read accepted while a write to the same word commits sees the RAM's old word.
        fwd_hit_reg  <= commit && !HWRITE && (idx == idx_reg);
        fwd_be_reg   <= be_reg;
        fwd_data_reg <= HWDATA;
      end
    end
  end

  ahb_sram_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .HCLK  (HCLK),
    .we    (commit),
    .be    (be_reg),
    .waddr (idx_reg),
    .wdata (HWDATA),
    .re    (ram_re),
    .raddr (idx),
    .rdata (ram_rdata)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
    assign rd_word[8*gi +: 8] = (fwd_hit_reg && fwd_be_reg[gi]) ? fwd_data_reg[8*gi +: 8]
                                                                : ram_rdata[8*gi +: 8];
  end

  assign HRDATA = ((state_reg == S_DATA) && !wr_reg) ? $signed(rd_word) : 32'sh0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Table-driven AHB-Lite transfers against ahb_sram_slave with an in-order
// scoreboard of expected data-phase responses, plus a mid-transfer reset sequence.
module tb_ahb_sram_slave;
  import AHP_MASTER_PKG::*;

  localparam int WS = 1;

  logic               HCLK = 1'b0;
  logic               HRESET;
  logic               HSEL;
  logic [31:0]        HADDR;
  logic               HWRITE;
  logic [2:0]         HSIZE;
  logic [2:0]         HBURST;
  HTRANS_ENUM         HTRANS;
  logic signed [31:0] HWDATA;
  logic               HREADY;
  logic               HREADYOUT;
  logic               HRESP;
  logic signed [31:0] HRDATA;

  ahb_sram_slave #(
    .ADDR_WIDTH (10),
    .WAIT_STATES(WS),
    .BASE_ADDR  (32'h0)
  ) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .HSEL     (HSEL),
    .HADDR    (HADDR),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HBURST   (HBURST),
    .HTRANS   (HTRANS),
    .HWDATA   (HWDATA),
    .HREADY   (HREADY),
    .HREADYOUT(HREADYOUT),
    .HRESP    (HRESP),
    .HRDATA   (HRDATA)
  );

  assign HREADY = HREADYOUT;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        sel;
    HTRANS_ENUM  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_resp;
    logic [31:0] exp_rdata;
    int          exp_waits;
  } vec_t;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] addr;
    logic        write;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  vec_t vecs[$];
  vec_t cur;
  bit   dp_active = 1'b0;
  int   waits = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic sel, input HTRANS_ENUM tr, input logic wr, input logic [2:0] sz,
                              input logic [2:0] bu, input logic [31:0] a, input logic [31:0] wd,
                              input logic er, input logic [31:0] rd);
    vec_t v;
    v.sel = sel; v.trans = tr; v.write = wr; v.size = sz; v.burst = bu;
    v.addr = a; v.wdata = wd; v.exp_resp = er; v.exp_rdata = rd;
    v.exp_waits = er ? 1 : WS;
    return v;
  endfunction

  function automatic vec_t wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                              input HTRANS_ENUM tr, input logic [2:0] bu);
    return mk(1'b1, tr, 1'b1, sz, bu, a, wd, 1'b0, 32'h0);
  endfunction

  function automatic vec_t rd(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] exp);
    return mk(1'b1, NON_SEQ, 1'b0, sz, 3'd0, a, 32'h0, 1'b0, exp);
  endfunction

  function automatic vec_t err(input logic [31:0] a, input logic [2:0] sz, input logic w, input logic [31:0] wd);
    return mk(1'b1, NON_SEQ, w, sz, 3'd0, a, wd, 1'b1, 32'h0);
  endfunction

  function automatic vec_t nop(input logic sel, input HTRANS_ENUM tr, input logic [31:0] a);
    return mk(sel, tr, 1'b0, HSIZE_WORD, 3'd0, a, 32'h0, 1'b0, 32'h0);
  endfunction

  // Observes one bus cycle at the falling edge: checks the current data phase and
  // records the address phase that the coming rising edge will accept.
  task automatic sample();
    logic take;
    exp_t e;
    take = HSEL && HREADY && ((HTRANS == NON_SEQ) || (HTRANS == SEQ));
    if (dp_active) begin
      if (sb.size() == 0) begin
        check("scoreboard_underflow", 64'(sb.size()), 64'd1);
      end else begin
        e = sb[0];
        if (!HREADYOUT) begin
          waits++;
          check($sformatf("wait_resp_rdata@%08h", e.addr), {31'h0, HRESP, HRDATA}, {31'h0, e.resp, 32'h0});
        end else begin
          check($sformatf("resp@%08h", e.addr), 64'(HRESP), 64'(e.resp));
          check($sformatf("rdata@%08h", e.addr), 64'(unsigned'(HRDATA)), 64'(e.rdata));
          check($sformatf("waits@%08h", e.addr), 64'(waits), 64'(e.waits));
          $display("txn %s addr=%08h resp=%0d rdata=%08h waits=%0d", e.write ? "WR" : "RD",
                   e.addr, HRESP, HRDATA, waits);
          void'(sb.pop_front());
        end
      end
    end else begin
      check("idle_ready_resp_rdata", {30'h0, HREADYOUT, HRESP, HRDATA}, {30'h0, 1'b1, 1'b0, 32'h0});
    end
    if (HREADYOUT) begin
      dp_active = take;
      waits     = 0;
      if (take) begin
        e.resp = cur.exp_resp; e.rdata = cur.exp_rdata; e.waits = cur.exp_waits;
        e.addr = cur.addr; e.write = cur.write;
        sb.push_back(e);
      end
    end
  endtask

  task automatic tick(output logic rdy);
    @(negedge HCLK);
    rdy = HREADYOUT;
    sample();
    @(posedge HCLK);
    #1;
  endtask

  // Presents one address phase and holds it until the bus accepts it.
  task automatic apply(input vec_t v);
    logic rdy;
    int   guard;
    HSEL = v.sel; HADDR = v.addr; HWRITE = v.write; HSIZE = v.size;
    HBURST = v.burst; HTRANS = v.trans;
    cur = v;
    rdy = 1'b0;
    guard = 0;
    while (!rdy && guard < 16) begin
      tick(rdy);
      guard++;
    end
    if (!rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL hready_timeout@%08h: got HREADYOUT=0 for %0d cycles, expected 1", v.addr, guard);
    end
    HWDATA = v.wdata;
  endtask

  initial begin
    logic rdy;

    vecs.push_back(wr(32'h10, HSIZE_WORD, 32'hDEADBEEF, NON_SEQ, 3'd0));
    vecs.push_back(rd(32'h10, HSIZE_WORD, 32'hDEADBEEF));
    vecs.push_back(nop(1'b0, IDLE, 32'h0));
    vecs.push_back(rd(32'h10, HSIZE_WORD, 32'hDEADBEEF));
    vecs.push_back(wr(32'h10, HSIZE_WORD, 32'h00000000, NON_SEQ, 3'd0));
    vecs.push_back(wr(32'h11, HSIZE_BYTE, 32'hCCCCAACC, NON_SEQ, 3'd0));
    vecs.push_back(rd(32'h10, HSIZE_WORD, 32'h0000AA00));
    vecs.push_back(wr(32'h12, HSIZE_HALF, 32'h1234EEEE, NON_SEQ, 3'd0));
    vecs.push_back(rd(32'h10, HSIZE_WORD, 32'h1234AA00));
    vecs.push_back(wr(32'h20, HSIZE_WORD, 32'h00000005, NON_SEQ, 3'd0));
    vecs.push_back(rd(32'h20, HSIZE_WORD, 32'h00000005));
    vecs.push_back(err(32'h21, HSIZE_WORD, 1'b1, 32'hFFFFFFFF));
    vecs.push_back(rd(32'h20, HSIZE_WORD, 32'h00000005));
    vecs.push_back(wr(32'h40, HSIZE_WORD, 32'h40404040, NON_SEQ, 3'd0));
    vecs.push_back(err(32'h40, 3'd3, 1'b1, 32'hFFFFFFFF));
    vecs.push_back(rd(32'h40, HSIZE_WORD, 32'h40404040));
    vecs.push_back(wr(32'h0, HSIZE_WORD, 32'h11111111, NON_SEQ, 3'd0));
    vecs.push_back(err(32'h1000, HSIZE_WORD, 1'b1, 32'hFFFFFFFF));
    vecs.push_back(rd(32'h0, HSIZE_WORD, 32'h11111111));
    vecs.push_back(err(32'h1000, HSIZE_WORD, 1'b0, 32'h0));
    vecs.push_back(nop(1'b1, IDLE, 32'h30));
    vecs.push_back(wr(32'h30, HSIZE_WORD, 32'h0BADF00D, NON_SEQ, 3'd0));
    vecs.push_back(err(32'h33, HSIZE_HALF, 1'b0, 32'h0));
    vecs.push_back(wr(32'h50, HSIZE_WORD, 32'hA0A0A0A0, NON_SEQ, 3'd3));
    vecs.push_back(wr(32'h54, HSIZE_WORD, 32'hA1A1A1A1, SEQ, 3'd3));
    vecs.push_back(mk(1'b1, BUSY, 1'b1, HSIZE_WORD, 3'd3, 32'h58, 32'h0, 1'b0, 32'h0));
    vecs.push_back(wr(32'h58, HSIZE_WORD, 32'hA2A2A2A2, SEQ, 3'd3));
    vecs.push_back(wr(32'h5C, HSIZE_WORD, 32'hA3A3A3A3, SEQ, 3'd3));
    vecs.push_back(rd(32'h50, HSIZE_WORD, 32'hA0A0A0A0));
    vecs.push_back(rd(32'h54, HSIZE_WORD, 32'hA1A1A1A1));
    vecs.push_back(rd(32'h58, HSIZE_WORD, 32'hA2A2A2A2));
    vecs.push_back(rd(32'h5C, HSIZE_WORD, 32'hA3A3A3A3));
    vecs.push_back(rd(32'h53, HSIZE_BYTE, 32'hA0A0A0A0));
    vecs.push_back(nop(1'b0, IDLE, 32'h0));

    HRESET = 1'b1;
    HSEL = 1'b0; HADDR = 32'h0; HWRITE = 1'b0; HSIZE = HSIZE_WORD;
    HBURST = 3'd0; HTRANS = IDLE; HWDATA = 32'sh0;
    cur = nop(1'b0, IDLE, 32'h0);
    #1;
    check("reset_hreadyout", 64'(HREADYOUT), 64'd1);
    check("reset_hresp", 64'(HRESP), 64'd0);
    check("reset_hrdata", 64'(unsigned'(HRDATA)), 64'd0);
    @(posedge HCLK);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end
    for (int i = 0; i < 3; i++) begin
      tick(rdy);
    end

    // Reset while a write sits in its wait state: outputs drop at once, no commit.
    apply(wr(32'h30, HSIZE_WORD, 32'hFFFFFFFF, NON_SEQ, 3'd0));
    HSEL = 1'b0; HTRANS = IDLE;
    cur = nop(1'b0, IDLE, 32'h0);
    check("pre_reset_in_wait", 64'(HREADYOUT), 64'd0);
    #2;
    HRESET = 1'b1;
    #1;
    check("midreset_hreadyout", 64'(HREADYOUT), 64'd1);
    check("midreset_hresp", 64'(HRESP), 64'd0);
    check("midreset_hrdata", 64'(unsigned'(HRDATA)), 64'd0);
    sb.delete();
    dp_active = 1'b0;
    waits = 0;
    @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(posedge HCLK);
    #1;
    apply(rd(32'h30, HSIZE_WORD, 32'h0BADF00D));
    apply(nop(1'b0, IDLE, 32'h0));
    for (int i = 0; i < 3; i++) begin
      tick(rdy);
    end

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
